// File: rtl/piso_serializer_if.sv
// Handshake and serial-line bundle for the parallel-in, serial-out transmitter.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             bit_en;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output bit_en, load_valid, load_data,
    input  load_ready, ser_out, ser_valid, frame_start, busy
  );

  modport slave (
    input  bit_en, load_valid, load_data,
    output load_ready, ser_out, ser_valid, frame_start, busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter. Takes a word on a valid/ready handshake
// and shifts it out one bit per bit_en strobe; a load on the last bit of a
// frame chains the next word with no idle gap on the line.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line idle, shreg cleared, ready for a new word
// S_SHIFT | frame in flight, r_bits_left bits remain including ser_out
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  piso_serializer_if.slave    bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bits_left;
  logic             r_frame_start;
  logic             r_ser_valid;

  logic             w_last;
  logic             w_load_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_shifted;

  // Last bit leaving the line this edge; the only point a new word may chain in.
  assign w_last       = (r_state == S_SHIFT) && bus.bit_en && (r_bits_left == CW'(1));
  assign w_load_ready = (r_state == S_IDLE) || w_last;
  assign w_accept     = bus.load_valid && w_load_ready;

  // Move the next bit toward the output end, zero fill behind it.
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shreg[WIDTH-1:1]};

  // Frame sequencing: reset, accept, shift, or return to idle after the last bit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_bits_left   <= '0;
      r_frame_start <= 1'b0;
      r_ser_valid   <= 1'b0;
    end else if (w_accept) begin
      r_state       <= S_SHIFT;
      r_shreg       <= bus.load_data;
      r_bits_left   <= CW'(WIDTH);
      r_frame_start <= 1'b1;
      r_ser_valid   <= 1'b1;
    end else if ((r_state == S_SHIFT) && bus.bit_en) begin
      if (w_last) begin
        r_state       <= S_IDLE;
        r_shreg       <= '0;
        r_bits_left   <= '0;
        r_frame_start <= 1'b0;
        r_ser_valid   <= 1'b0;
      end else begin
        r_shreg       <= w_shifted;
        r_bits_left   <= r_bits_left - CW'(1);
        r_frame_start <= 1'b0;
      end
    end
  end

  assign bus.load_ready  = w_load_ready;
  assign bus.ser_out     = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign bus.ser_valid   = r_ser_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = (r_state == S_SHIFT);

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter for the team's flip-flop-based datapath library. It accepts a parallel word through a valid/ready handshake and shifts it out one bit per enabled clock edge. It is the sending end of a serial bit stream; the matching serial-in receiver reassembles the words. An external `bit_en` strobe paces the bit rate, and a back-to-back load keeps the line continuously valid across word boundaries.

## Interface
- `WIDTH`, 8: word length in bits; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 = `load_data[WIDTH-1]` is transmitted first; 0 = `load_data[0]` is transmitted first.

- `clk`  in  1  clock. All state changes on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low, sampled on the `clk` rising edge.
- `bit_en`  in  1  bit-rate strobe. Advances the serial stream by one bit when high.
- `load_valid`  in  1  parallel word offered.
- `load_data`  in  WIDTH  parallel word.
- `load_ready`  out  1  word will be accepted on this edge if `load_valid` is high.
- `ser_out`  out  1  serial data bit.
- `ser_valid`  out  1  `ser_out` carries a frame bit.
- `frame_start`  out  1  `ser_out` is the first bit of a frame.
- `busy`  out  1  state is SHIFT.

## Operation
- Registers:
  - `state` ∈ {IDLE, SHIFT}.
  - `shreg[WIDTH-1:0]`.
  - `bits_left`, width clog2(WIDTH+1). Counts bits remaining, including the bit currently on `ser_out`.
  - `frame_start`, `ser_valid`.
- `ser_out`:
  - Equals `shreg[WIDTH-1]` when MSB_FIRST=1, else `shreg[0]`.
  - Driven directly from the register, with no combinational path from the inputs.
- `load_ready`:
  - Combinational.
  - Equals `(state==IDLE) | (state==SHIFT & bit_en & bits_left==1)`.
- Accept means `load_valid & load_ready` at a rising edge. On accept:
  - `shreg` ← `load_data`
  - `bits_left` ← WIDTH
  - `ser_valid` ← 1
  - `frame_start` ← 1
  - `state` ← SHIFT
- IDLE with no accept:
  - All registers hold. `shreg` = 0, so `ser_out` = 0.
  - `bit_en` is ignored.
- SHIFT, `bit_en`=1, `bits_left`>1:
  - Shift `shreg` toward the output end. MSB_FIRST=1 shifts left; otherwise shifts right. Zero fill.
  - `bits_left` decrements.
  - `frame_start` ← 0.
- SHIFT, `bit_en`=1, `bits_left`==1 (last bit):
  - If `load_valid` is high, perform the accept (back-to-back frame).
  - Otherwise: `state` ← IDLE, `shreg` ← 0, `bits_left` ← 0, `ser_valid` ← 0, `frame_start` ← 0.
- SHIFT, `bit_en`=0:
  - Everything holds, including `frame_start`.
  - `load_valid` is ignored (`load_ready`=0).
- `load_valid` during SHIFT, before the last bit: not accepted. The source holds `load_data` until `load_ready`.
- `busy` = (`state`==SHIFT). `ser_valid` equals `busy` at all times.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - `state`=IDLE, `shreg`=0, `bits_left`=0.
  - `ser_out`=0, `ser_valid`=0, `frame_start`=0, `busy`=0.
  - `load_ready`=1 from the following cycle.
- Reset has priority over accept, shift and `bit_en`. It applies mid-frame; the partial frame is discarded.
- Latency: a word accepted at edge N puts its first bit on `ser_out` after edge N, with `frame_start`=1.
- Each bit stays on `ser_out` until the next edge that samples `bit_en`=1.
- With `bit_en` tied high:
  - A frame occupies exactly WIDTH cycles.
  - A back-to-back load gives 100% line utilisation: `ser_valid` never drops between frames.
- Idle gap: the earliest next accept after a frame ends is the edge after the return to IDLE. `ser_valid` is low for at least 1 cycle.
- The `load_data` value is sampled only on the accept edge. Later changes on `load_data` have no effect on the frame in flight.

## Test plan
- Reset: drive `load_valid`=1 with `load_data`=8'hFF while `rst_n`=0 for 3 edges. Required: `ser_valid`=0, `busy`=0, `ser_out`=0 on every cycle, with no frame started. Then release reset: `load_ready`=1.
- Single word, MSB_FIRST=1, `bit_en`=1, `load_data`=8'h01. Required:
  - `ser_out` sequence 0,0,0,0,0,0,0,1 on cycles 1–8.
  - `frame_start`=1 on cycle 1 only.
  - `ser_valid`=0 on cycle 9.
- Same word with MSB_FIRST=0. Required: `ser_out` sequence 1,0,0,0,0,0,0,0.
- Back-to-back: load 8'hF0, then hold `load_valid`=1 with 8'h0F. Required:
  - 16 contiguous bits 1111000000001111.
  - `ser_valid` high throughout.
  - `frame_start` high on cycles 1 and 9.
  - `load_ready` high only on cycle 8 during SHIFT.
- Paced: `bit_en` high every 3rd cycle, word 8'hA5. Required:
  - Each bit held exactly 3 cycles.
  - `frame_start` high for the full first 3 cycles.
  - `load_valid` pulses mid-frame are not accepted.
- Reset mid-frame: assert `rst_n`=0 at bit 4 of 8'hA5. Required:
  - All outputs are at their reset values on the next cycle.
  - A new word 8'h3C afterwards transmits fully and correctly.
